univ_shift_reg: RTL and testbench

Parametrised universal shift register with clock enable: a WIDTH-bit register supporting hold, logical shift, rotate, arithmetic shift, parallel load and clear, selected by a 3-bit mode. It also counts shift operations since the last load/clear and pulses a word-complete flag after WIDTH shifts. It is the multi-bit, multi-mode successor to the 1-bit enable-register cell and serves as the serialiser/deserialiser and general data-path register in later lab designs.

---
 rtl/univ_shift_reg_if.sv | 31 +++
 rtl/univ_shift_reg.sv | 100 ++++++++++
 tb/tb_univ_shift_reg.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/univ_shift_reg_if.sv
// Port bundle for univ_shift_reg: control/data inputs from the master and the
// register view returned by the slave.
interface univ_shift_reg_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH + 1);

  // No valid/ready pair on this bundle: ce qualifies every input. When ce is
  // high on a rising edge, mode/din/sin_l/sin_r are consumed that edge. When
  // ce is low they are ignored.
  logic             ce;
  logic [2:0]       mode;
  logic [WIDTH-1:0] din;
  logic             sin_l;
  logic             sin_r;
  logic [WIDTH-1:0] qout;
  logic             sout_l;
  logic             sout_r;
  logic [CW-1:0]    shift_cnt;
  logic             word_done;

  modport master (
    output ce, mode, din, sin_l, sin_r,
    input  qout, sout_l, sout_r, shift_cnt, word_done
  );

  modport slave (
    input  ce, mode, din, sin_l, sin_r,
    output qout, sout_l, sout_r, shift_cnt, word_done
  );
endinterface

// File: rtl/univ_shift_reg.sv
// WIDTH-bit universal shift register: hold, shift, rotate, arithmetic shift,
// load and clear, with a saturating shift counter and a word-complete pulse.
module univ_shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  univ_shift_reg_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    MODE_HOLD  = 3'b000,
    MODE_SHL   = 3'b001,
    MODE_SHR   = 3'b010,
    MODE_LOAD  = 3'b011,
    MODE_ROTL  = 3'b100,
    MODE_ROTR  = 3'b101,
    MODE_ASR   = 3'b110,
    MODE_CLEAR = 3'b111
  } mode_e;

  logic [WIDTH-1:0] q_r;
  logic [CW-1:0]    cnt_r;
  logic             done_r;

  mode_e            mode_d;
  logic [WIDTH-1:0] q_next;
  logic             is_shift;
  logic             is_restart;

  assign mode_d = mode_e'(bus.mode);

  always_comb begin
    q_next     = q_r;
    is_shift   = 1'b0;
    is_restart = 1'b0;
    case (mode_d)
      MODE_HOLD:  q_next = q_r;
      MODE_SHL: begin
        q_next   = {q_r[WIDTH-2:0], bus.sin_r};
        is_shift = 1'b1;
      end
      MODE_SHR: begin
        q_next   = {bus.sin_l, q_r[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_LOAD: begin
        q_next     = bus.din;
        is_restart = 1'b1;
      end
      MODE_ROTL: begin
        q_next   = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        is_shift = 1'b1;
      end
      MODE_ROTR: begin
        q_next   = {q_r[0], q_r[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_ASR: begin
        // Sign bit is replicated; sin_l plays no part here.
        q_next   = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
        is_shift = 1'b1;
      end
      MODE_CLEAR: begin
        q_next     = '0;
        is_restart = 1'b1;
      end
      default: q_next = q_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_r    <= '0;
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else if (!bus.ce) begin
      done_r <= 1'b0;
    end else begin
      q_r    <= q_next;
      done_r <= 1'b0;
      if (is_restart) begin
        cnt_r <= '0;
      end else if (is_shift && cnt_r != CNT_FULL) begin
        // Pulse only on the step into saturation, so later shifts stay quiet.
        cnt_r  <= cnt_r + CW'(1);
        done_r <= (cnt_r == CNT_LAST);
      end
    end
  end

  assign bus.qout      = q_r;
  assign bus.sout_l    = q_r[WIDTH-1];
  assign bus.sout_r    = q_r[0];
  assign bus.shift_cnt = cnt_r;
  assign bus.word_done = done_r;
endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (WIDTH=8): directed scenarios plus randomized
// traffic, all compared with an integer-arithmetic reference model.
module tb_univ_shift_reg;
  localparam int W  = 8;
  localparam int CW = $clog2(W + 1);
  localparam int M  = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  // reference model state
  int   mq = 0;
  int   mcnt = 0;
  bit   mdone = 0;
  logic exp_q[$];

  univ_shift_reg_if #(.WIDTH(W)) bus ();

  univ_shift_reg #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Model: the register value is an integer in [0, 2**W) and every mode is
  // plain arithmetic on it.
  task automatic model_update(input bit r, input bit c, input int m, input int d,
                              input int sl, input int sr);
    bit sh;
    if (r) begin
      mq = 0; mcnt = 0; mdone = 0;
      return;
    end
    mdone = 0;
    if (!c) return;
    sh = 1;
    case (m)
      0: sh = 0;
      1: mq = (mq * 2 + sr) % M;
      2: mq = mq / 2 + sl * (M / 2);
      3: begin mq = d; mcnt = 0; sh = 0; end
      4: mq = (mq * 2) % M + mq / (M / 2);
      5: mq = mq / 2 + (mq % 2) * (M / 2);
      6: mq = mq / 2 + ((mq >= M / 2) ? M / 2 : 0);
      default: begin mq = 0; mcnt = 0; sh = 0; end
    endcase
    if (sh && mcnt < W) begin
      mcnt = mcnt + 1;
      mdone = (mcnt == W);
    end
  endtask

  task automatic step(input bit r, input bit c, input int m, input int d,
                      input int sl, input int sr);
    @(negedge clk);
    rst       = r;
    bus.ce    = c;
    bus.mode  = 3'(m);
    bus.din   = W'(d);
    bus.sin_l = sl[0];
    bus.sin_r = sr[0];
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_update(r, c, m, d, sl, sr);
  endtask

  task automatic test_reset();
    step(1, 1, 3, 8'hFF, 1, 1);
    checks++;
    if (bus.qout !== 8'h00) begin
      failures++; $display("FAIL reset_qout got=%h exp=00", bus.qout);
    end
    checks++;
    if (bus.shift_cnt !== '0) begin
      failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.shift_cnt);
    end
    checks++;
    if (bus.word_done !== 1'b0 || bus.sout_l !== 1'b0 || bus.sout_r !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags done=%b soutl=%b soutr=%b exp=0", bus.word_done, bus.sout_l, bus.sout_r);
    end
  endtask

  task automatic test_load_hold();
    step(0, 1, 3, 8'hA5, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 8'h00, 1, 1);
      checks++;
      if (bus.qout !== 8'hA5 || bus.shift_cnt !== '0 || bus.word_done !== 1'b0) begin
        failures++;
        $display("FAIL ce_low_hold q=%h cnt=%0d done=%b exp q=a5 cnt=0 done=0", bus.qout, bus.shift_cnt, bus.word_done);
      end
    end
    step(0, 1, 0, 8'h3C, 1, 1);
    checks++;
    if (bus.qout !== 8'hA5 || bus.shift_cnt !== '0) begin
      failures++; $display("FAIL mode_hold q=%h cnt=%0d exp q=a5 cnt=0", bus.qout, bus.shift_cnt);
    end
  endtask

  task automatic test_serialise();
    logic [7:0] pat;
    logic       e;
    pat = 8'hA5;
    step(0, 1, 3, 8'hA5, 0, 0);
    for (int i = 7; i >= 0; i--) exp_q.push_back(pat[i]);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.sout_l !== e) begin
        failures++; $display("FAIL serial_bit%0d got=%b exp=%b", i, bus.sout_l, e);
      end
      step(0, 1, 1, 0, 0, 0);
      checks++;
      if (bus.word_done !== (i == 7)) begin
        failures++; $display("FAIL serial_done%0d got=%b exp=%b", i, bus.word_done, (i == 7));
      end
    end
    checks++;
    if (bus.qout !== 8'h00 || bus.shift_cnt !== CW'(8)) begin
      failures++; $display("FAIL serial_end q=%h cnt=%0d exp q=00 cnt=8", bus.qout, bus.shift_cnt);
    end
    step(0, 1, 1, 0, 0, 1);
    checks++;
    if (bus.shift_cnt !== CW'(8) || bus.word_done !== 1'b0 || bus.qout !== 8'h01) begin
      failures++;
      $display("FAIL serial_sat q=%h cnt=%0d done=%b exp q=01 cnt=8 done=0", bus.qout, bus.shift_cnt, bus.word_done);
    end
  endtask

  task automatic test_deserialise();
    logic [7:0] bits;
    int pulses;
    bits = 8'b1101_0011;  // bit0 is the first serial input
    for (int pass = 0; pass < 2; pass++) begin
      pulses = 0;
      step(0, 1, 7, 0, 0, 0);
      for (int i = 0; i < 8; i++) begin
        step(0, 1, 2, 0, int'(bits[i]), 0);
        if (bus.word_done === 1'b1) pulses++;
        if (pass == 1) begin
          for (int g = $urandom_range(0, 3); g > 0; g--) begin
            step(0, 0, $urandom_range(0, 7), $urandom, 1, 1);
            if (bus.word_done === 1'b1) pulses++;
          end
        end
      end
      checks++;
      if (bus.qout !== 8'hD3 || pulses != 1) begin
        failures++; $display("FAIL deserial_pass%0d q=%h pulses=%0d exp q=d3 pulses=1", pass, bus.qout, pulses);
      end
    end
  endtask

  task automatic test_rotate_arith();
    logic [7:0] exp_v[6];
    int modes[6];
    exp_v = '{8'h81, 8'h03, 8'h81, 8'hC0, 8'hE0, 8'h20};
    modes = '{3, 4, 5, 5, 6, 6};
    for (int i = 0; i < 6; i++) begin
      if (i == 5) step(0, 1, 3, 8'h40, 1, 1);
      step(0, 1, modes[i], 8'h81, 1, 1);
      checks++;
      if (bus.qout !== exp_v[i]) begin
        failures++; $display("FAIL rot_arith%0d got=%h exp=%h", i, bus.qout, exp_v[i]);
      end
    end
  endtask

  task automatic test_boundary();
    int pulses;
    for (int k = 0; k < 3; k++) begin
      step(0, 1, 3, 8'h5A, 0, 0);
      for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0, 1);
      // k=0 clear, k=1 reset, k=2 load on the count-7 edge
      step(k == 1, 1, (k == 2) ? 3 : 7, 8'h99, 1, 1);
      checks++;
      if (bus.qout !== ((k == 2) ? 8'h99 : 8'h00) || bus.shift_cnt !== '0 || bus.word_done !== 1'b0) begin
        failures++;
        $display("FAIL boundary%0d q=%h cnt=%0d done=%b", k, bus.qout, bus.shift_cnt, bus.word_done);
      end
    end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 2, 0, 1, 0);
      if (bus.word_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || bus.shift_cnt !== CW'(8)) begin
      failures++; $display("FAIL boundary_fresh pulses=%0d cnt=%0d exp pulses=1 cnt=8", pulses, bus.shift_cnt);
    end
  endtask

  task automatic test_random();
    int m;
    for (int i = 0; i < 400; i++) begin
      m = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 2);
      if ($urandom_range(0, 15) == 0) m = 3;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, m, $urandom_range(0, M - 1),
           $urandom_range(0, 1), $urandom_range(0, 1));
      checks++;
      if (bus.qout !== W'(mq) || bus.shift_cnt !== CW'(mcnt) || bus.word_done !== mdone ||
          bus.sout_l !== W'(mq) >> (W - 1) || bus.sout_r !== 1'(mq % 2)) begin
        failures++;
        $display("FAIL random%0d q=%h cnt=%0d done=%b exp q=%h cnt=%0d done=%b",
                 i, bus.qout, bus.shift_cnt, bus.word_done, W'(mq), mcnt, mdone);
      end
    end
  endtask

  initial begin
    bus.ce = 1'b0; bus.mode = '0; bus.din = '0; bus.sin_l = 1'b0; bus.sin_r = 1'b0;
    test_reset();
    test_load_hold();
    test_serialise();
    test_deserialise();
    test_rotate_arith();
    test_boundary();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
